// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with registered read data and status flags.
// Status outputs: exact occupancy count, half_full / half_empty derived from
// DEPTH, and almost_full / almost_empty against run-time thresholds.
// Optional feature macro SYNC_FIFO_ERR_EN adds the sticky overflow/underflow
// outputs. When the macro is undefined, rejected requests are dropped silently.
module sync_fifo_prog #(
  parameter int DATA_LINES = 8,
  parameter int ADDR_LINES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_LINES-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_LINES-1:0] rdata,
  input  logic [ADDR_LINES:0]   af_thresh,
  input  logic [ADDR_LINES:0]   ae_thresh,
  output logic [ADDR_LINES:0]   count,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  half_full,
  output logic                  half_empty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_LINES;
  localparam logic [ADDR_LINES:0] DEPTH_C = (ADDR_LINES+1)'(DEPTH);
  localparam logic [ADDR_LINES:0] HALF_C  = (ADDR_LINES+1)'(DEPTH / 2);
  localparam logic [ADDR_LINES:0] ONE_C   = (ADDR_LINES+1)'(1);

  // Storage array; no reset so it maps onto block RAM.
  logic [DATA_LINES-1:0] mem_reg [DEPTH];

  logic [ADDR_LINES-1:0] wptr_reg;
  logic [ADDR_LINES-1:0] rptr_reg;
  logic [ADDR_LINES:0]   count_reg;
  logic [ADDR_LINES:0]   count_next;
  logic [DATA_LINES-1:0] rdata_reg;
  logic                  wfull_reg;
  logic                  rempty_reg;
  logic                  half_full_reg;
  logic                  almost_full_reg;
  logic                  almost_empty_reg;
  logic                  wr_ok;
  logic                  rd_ok;

  // Requests are qualified by the registered flags of the current cycle, so a
  // read against an empty FIFO is always rejected even when a write lands in
  // the same cycle; this also rules out read-during-write on one address.
  assign wr_ok = winc & ~wfull_reg;
  assign rd_ok = rinc & ~rempty_reg;

  // Next occupancy: +1 on write only, -1 on read only, unchanged otherwise.
  always_comb begin
    count_next = count_reg;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + ONE_C;
      2'b01:   count_next = count_reg - ONE_C;
      default: count_next = count_reg;
    endcase
  end

  // Memory write port; gated by rst so a write racing a reset is discarded.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      mem_reg[wptr_reg] <= wdata;
    end
  end

  // Pointer advance; ADDR_LINES-bit pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (wr_ok) wptr_reg <= wptr_reg + 1'b1;
      if (rd_ok) rptr_reg <= rptr_reg + 1'b1;
    end
  end

  // Registered read data: updates only on an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= '0;
    end else if (rd_ok) begin
      rdata_reg <= mem_reg[rptr_reg];
    end
  end

  // Occupancy and all flags are registered from count_next so they agree
  // with count in every cycle; thresholds are sampled on every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg        <= '0;
      wfull_reg        <= 1'b0;
      rempty_reg       <= 1'b1;
      half_full_reg    <= 1'b0;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      count_reg        <= count_next;
      wfull_reg        <= (count_next == DEPTH_C);
      rempty_reg       <= (count_next == '0);
      half_full_reg    <= (count_next >= HALF_C);
      almost_full_reg  <= (count_next >= af_thresh);
      almost_empty_reg <= (count_next <= ae_thresh);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  // Sticky error flags: set on any rejected request, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (winc && wfull_reg)  overflow_reg  <= 1'b1;
      if (rinc && rempty_reg) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

  assign rdata        = rdata_reg;
  assign count        = count_reg;
  assign wfull        = wfull_reg;
  assign rempty       = rempty_reg;
  assign half_full    = half_full_reg;
  assign half_empty   = ~half_full_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed plus randomized stimulus for sync_fifo_prog,
// checked against a queue-based reference model of the FIFO.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic [AW:0]   af_thresh = 5'd12;
  logic [AW:0]   ae_thresh = 5'd3;
  logic [AW:0]   count;
  logic          wfull, rempty, half_full, half_empty, almost_full, almost_empty;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow, underflow;
`endif

  sync_fifo_prog #(.DATA_LINES(DW), .ADDR_LINES(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .rdata        (rdata),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .count        (count),
    .wfull        (wfull),
    .rempty       (rempty),
    .half_full    (half_full),
    .half_empty   (half_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model: contents in order, last read word, sticky errors.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_rdata = '0;
  bit            exp_ovf   = 1'b0;
  bit            exp_unf   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Every output compared against what the model's occupancy implies.
  task automatic check_outputs();
    int n;
    n = model_q.size();
    check_eq("count",        count,        n);
    check_eq("wfull",        wfull,        n == DEPTH);
    check_eq("rempty",       rempty,       n == 0);
    check_eq("half_full",    half_full,    n >= DEPTH / 2);
    check_eq("half_empty",   half_empty,   n < DEPTH / 2);
    check_eq("almost_full",  almost_full,  n >= int'(af_thresh));
    check_eq("almost_empty", almost_empty, n <= int'(ae_thresh));
    check_eq("rdata",        rdata,        exp_rdata);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("overflow",     overflow,     exp_ovf);
    check_eq("underflow",    underflow,    exp_unf);
`endif
  endtask

  // Reset values are fixed constants, independent of thresholds.
  task automatic check_reset();
    check_eq("rst_count",        count,        0);
    check_eq("rst_rdata",        rdata,        0);
    check_eq("rst_wfull",        wfull,        0);
    check_eq("rst_rempty",       rempty,       1);
    check_eq("rst_half_full",    half_full,    0);
    check_eq("rst_half_empty",   half_empty,   1);
    check_eq("rst_almost_full",  almost_full,  0);
    check_eq("rst_almost_empty", almost_empty, 1);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("rst_overflow",     overflow,     0);
    check_eq("rst_underflow",    underflow,    0);
`endif
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // One clock of traffic: drive, clock, update the model, compare.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    bit wr_ok, rd_ok;
    winc  = w;
    rinc  = r;
    wdata = d;
    wr_ok = w && (model_q.size() < DEPTH);
    rd_ok = r && (model_q.size() > 0);
    if (w && model_q.size() == DEPTH) exp_ovf = 1'b1;
    if (r && model_q.size() == 0)     exp_unf = 1'b1;
    @(posedge clk);
    #1;
    if (rd_ok) exp_rdata = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
    cyc++;
    $display("[TB] cyc %0d w=%b r=%b d=%02h af=%0d ae=%0d -> count=%0d rdata=%02h",
             cyc, w, r, d, af_thresh, ae_thresh, count, rdata);
    check_outputs();
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    int pw, pr;
    // Reset held from time zero.
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    model_reset();
    rst = 1'b1;

    // Fill 0x01..0x10, then one extra write that must be dropped.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i));
    cycle(1'b1, 1'b0, 8'h55);

    // Drain 16 words plus one read against empty (rdata must hold 0x10).
    for (int i = 0; i <= DEPTH; i++) cycle(1'b0, 1'b1, '0);
    check_eq("hold_last_rdata", rdata, 8'h10);

    // Thresholds 12/3: write 12, then raise af_thresh to 14 while idle.
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, DW'($urandom));
    af_thresh = 5'd14;
    cycle(1'b0, 1'b0, '0);

    // Top up to full, then simultaneous write(0xAA)+read on full.
    while (model_q.size() < DEPTH) cycle(1'b1, 1'b0, DW'($urandom_range(0, 8'hA9)));
    cycle(1'b1, 1'b1, 8'hAA);
    while (model_q.size() > 0) begin
      cycle(1'b0, 1'b1, '0);
      check_eq("no_aa_read", rdata == 8'hAA, 0);
    end

    // Simultaneous write+read on empty: only the write lands.
    cycle(1'b1, 1'b1, 8'h3C);
    cycle(1'b0, 1'b1, '0);

    // Threshold extremes: af 0 forces almost_full, af > DEPTH never sets it.
    af_thresh = 5'd0;
    ae_thresh = 5'd0;
    cycle(1'b0, 1'b0, '0);
    af_thresh = 5'd20;
    ae_thresh = 5'd16;
    while (model_q.size() < DEPTH) cycle(1'b1, 1'b0, DW'($urandom));
    while (model_q.size() > 0) cycle(1'b0, 1'b1, '0);

    // Pointer wrap with occupancy held at 5.
    af_thresh = 5'd6;
    ae_thresh = 5'd5;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, DW'($urandom));
    while (model_q.size() > 0) cycle(1'b0, 1'b1, '0);

    // Randomized traffic with drifting write/read bias and thresholds.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      if ($urandom_range(0, 9) == 0) af_thresh = 5'($urandom_range(0, DEPTH + 2));
      if ($urandom_range(0, 9) == 0) ae_thresh = 5'($urandom_range(0, DEPTH + 2));
      cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, DW'($urandom));
    end

    // Reset mid-stream: outputs return to reset values without a clock.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, DW'($urandom));
    winc = 1'b1;
    rinc = 1'b1;
    rst  = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(posedge clk);
    #1;
    check_reset();
    winc = 1'b0;
    rinc = 1'b0;
    rst  = 1'b1;
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
